fp_result_writer: RTL and testbench

//   Write-side counterpart of the operand memory reader: accepts FP16 products plus class flags from
//   the FP16 multiplier via valid/ready, packs each into a 32-bit result word, stores it at a

---
 rtl/fp16_pkg.sv | 36 +++
 rtl/fp_result_ram.sv | 51 +++++
 rtl/fp_result_writer.sv | 106 ++++++++++
 tb/tb_fp_result_writer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 result-writer definitions: widths, flag bit positions, writer FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Config macro: FP_RESULT_FLAGS_EN selects whether the class flags are kept alongside the product.
package fp16_pkg;

  localparam int FP16_W   = 16;
  localparam int RESULT_W = 32;
  localparam int FLAGS_W  = 6;

  // Flag vector bit positions: {snan,qnan,inf,zero,subnormal,normal}
  localparam int FLAG_SNAN      = 5;
  localparam int FLAG_QNAN      = 4;
  localparam int FLAG_INF       = 3;
  localparam int FLAG_ZERO      = 2;
  localparam int FLAG_SUBNORMAL = 1;
  localparam int FLAG_NORMAL    = 0;

  // Writer FSM encoding
  typedef logic [1:0] wr_state_t;
  localparam wr_state_t ST_IDLE  = 2'd0;
  localparam wr_state_t ST_WRITE = 2'd1;
  localparam wr_state_t ST_FULL  = 2'd2;

`ifdef FP_RESULT_FLAGS_EN
  localparam int HOLD_W = FLAGS_W + FP16_W;   // {flags, product}
`else
  localparam int HOLD_W = FP16_W;             // product only
`endif

  // The hold word is laid out so that zero-extension gives the stored result word.
  function automatic logic [RESULT_W-1:0] pack_result(input logic [HOLD_W-1:0] hold);
    return {{(RESULT_W-HOLD_W){1'b0}}, hold};
  endfunction

endpackage

// File: rtl/fp_result_ram.sv
// Result storage: DEPTH x 32 array, one synchronous write port, one combinational read port.
// Latency: write lands at the clock edge; read is combinational (old data until the edge).
// Backpressure: none; the writer controls when we is asserted.
// Ports: clk, rst (async, active-high, clears valid bits only), clear (sync invalidate all),
//        we/waddr/wdata (write port), raddr/rdata (read port, 0 for invalid or out-of-range).
module fp_result_ram
  import fp16_pkg::*;
#(
  parameter int DEPTH  = 21,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [RESULT_W-1:0] wdata,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [RESULT_W-1:0] rdata
);

  logic [RESULT_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]    valid;

  // Data array is intentionally not reset; the valid bits gate every read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (clear) begin
      valid <= '0;
    end else if (we) begin
      valid[waddr] <= 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    if (32'(raddr) < DEPTH) begin
      if (valid[raddr]) begin
        rdata = mem[raddr];
      end
    end
  end

endmodule

// File: rtl/fp_result_writer.sv
// Packs FP16 products (plus class flags when FP_RESULT_FLAGS_EN) into 32-bit words at sequential addresses.
// Latency: accept edge -> write edge one cycle later; throughput one result per two cycles.
// Backpressure: in_ready high only in IDLE; once DEPTH entries are written it stays low until rst/clear.
// Ports: clk, rst (async, active-high), clear (sync restart), in_valid/in_ready/in_product/in_flags
//        (producer side), rd_addr/rd_data (combinational readback), wr_count, full, overflow (sticky).
// Config macro: FP_RESULT_FLAGS_EN -> word = {10'b0, flags, product}; otherwise {16'b0, product}.
module fp_result_writer
  import fp16_pkg::*;
#(
  parameter int DEPTH  = 21,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FP16_W-1:0]   in_product,
  input  logic [FLAGS_W-1:0]  in_flags,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [RESULT_W-1:0] rd_data,
  output logic [ADDR_W:0]     wr_count,
  output logic                full,
  output logic                overflow
);

  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  wr_state_t           state;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [HOLD_W-1:0]   hold;
  logic [HOLD_W-1:0]   hold_next;
  logic                ram_we;

`ifdef FP_RESULT_FLAGS_EN
  assign hold_next = {in_flags, in_product};
`else
  logic unused_flags;
  assign unused_flags = ^in_flags;
  assign hold_next    = in_product;
`endif

  assign in_ready = (state == ST_IDLE);
  assign full     = (wr_count == DEPTH_CNT);
  // A clear in the WRITE cycle drops the pending word.
  assign ram_we   = (state == ST_WRITE) && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      wr_count <= '0;
      overflow <= 1'b0;
      hold     <= '0;
    end else if (clear) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      wr_count <= '0;
      overflow <= 1'b0;
      hold     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            hold  <= hold_next;
            state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          wr_count <= wr_count + 1'b1;
          // Pointer parks on the last entry; no wrap-around.
          if (wr_ptr == LAST_PTR) begin
            state <= ST_FULL;
          end else begin
            wr_ptr <= wr_ptr + 1'b1;
            state  <= ST_IDLE;
          end
        end
        ST_FULL: begin
          if (in_valid) begin
            overflow <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  fp_result_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (pack_result(hold)),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_fp_result_writer.sv
// Directed bench for fp_result_writer: table of product/flag vectors plus hand sequences
// for fill/overflow, clear during write, clear with a coincident beat, and async reset.
module tb_fp_result_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_product;
  logic [5:0]  in_flags;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [5:0]  wr_count;
  logic        full;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_result_writer #(.DEPTH(21), .ADDR_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_product (in_product),
    .in_flags   (in_flags),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_count   (wr_count),
    .full       (full),
    .overflow   (overflow)
  );

  typedef struct {
    logic [15:0] p;
    logic [5:0]  f;
    logic [31:0] w_fl;   // expected word with flags kept
    logic [31:0] w_nf;   // expected word product only
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int i);
`ifdef FP_RESULT_FLAGS_EN
    return tbl[i].w_fl;
`else
    return tbl[i].w_nf;
`endif
  endfunction

  function automatic logic [31:0] fill_word(input int k);
`ifdef FP_RESULT_FLAGS_EN
    return 32'h0001_1000 + 32'(k);
`else
    return 32'h0000_1000 + 32'(k);
`endif
  endfunction

  // Called at posedge+1 with the writer idle and the target address unwritten.
  task automatic write_item(input logic [15:0] p, input logic [5:0] f,
                            input logic [31:0] exp, input logic [4:0] addr);
    check("ready_idle", in_ready, 1);
    in_valid = 1'b1; in_product = p; in_flags = f;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rd_addr  = addr;
    #1;
    check("ready_busy", in_ready, 0);
    check("read_before_write_edge", rd_data, 32'h0);
    @(posedge clk); #1;
    check("stored_word", rd_data, exp);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    int k;
    int cycles;

    tbl[0] = '{16'h4000, 6'b000001, 32'h0001_4000, 32'h0000_4000};
    tbl[1] = '{16'h7C00, 6'b001000, 32'h0008_7C00, 32'h0000_7C00};
    tbl[2] = '{16'h7E01, 6'b010000, 32'h0010_7E01, 32'h0000_7E01};
    tbl[3] = '{16'h0000, 6'b000100, 32'h0004_0000, 32'h0000_0000};
    tbl[4] = '{16'h8001, 6'b000010, 32'h0002_8001, 32'h0000_8001};
    tbl[5] = '{16'h7D00, 6'b100000, 32'h0020_7D00, 32'h0000_7D00};
    tbl[6] = '{16'h3C00, 6'b101010, 32'h002A_3C00, 32'h0000_3C00};

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
    in_product = '0; in_flags = '0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_wr_count", wr_count, 0);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_read0", rd_data, 32'h0);
    @(posedge clk); #1;

    // Table vectors to consecutive addresses
    for (int i = 0; i < 7; i++) begin
      write_item(tbl[i].p, tbl[i].f, exp_word(i), 5'(i));
      check("count_after_write", wr_count, 32'(i + 1));
    end
    for (int i = 0; i < 7; i++) begin
      rd_addr = 5'(i); #1;
      check("readback_table", rd_data, exp_word(i));
    end
    rd_addr = 5'd10; #1; check("read_unwritten_10", rd_data, 32'h0);
    rd_addr = 5'd25; #1; check("read_oob_25", rd_data, 32'h0);
    rd_addr = 5'd31; #1; check("read_oob_31", rd_data, 32'h0);
    check("not_full_7", full, 0);

    // Clear during WRITE of the third item
    @(posedge clk); #1;
    do_clear();
    check("clear_count", wr_count, 0);
    rd_addr = 5'd0; #1; check("clear_invalidates_0", rd_data, 32'h0);
    write_item(tbl[0].p, tbl[0].f, exp_word(0), 5'd0);
    write_item(tbl[1].p, tbl[1].f, exp_word(1), 5'd1);
    in_valid = 1'b1; in_product = tbl[2].p; in_flags = tbl[2].f;
    @(posedge clk); #1;
    in_valid = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clr_wr_count", wr_count, 0);
    check("clr_in_ready", in_ready, 1);
    rd_addr = 5'd2; #1; check("clr_addr2_empty", rd_data, 32'h0);
    rd_addr = 5'd0; #1; check("clr_addr0_empty", rd_data, 32'h0);
    write_item(tbl[3].p, tbl[3].f, exp_word(3), 5'd0);
    check("after_clr_count", wr_count, 1);
    write_item(tbl[4].p, tbl[4].f, exp_word(4), 5'd1);
    write_item(tbl[5].p, tbl[5].f, exp_word(5), 5'd2);
    rd_addr = 5'd5; #1; check("read_unwritten_5", rd_data, 32'h0);

    // Clear coinciding with a beat in IDLE: beat dropped
    in_valid = 1'b1; in_product = tbl[6].p; in_flags = tbl[6].f;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    check("clr_beat_ready", in_ready, 1);
    check("clr_beat_count", wr_count, 0);
    @(posedge clk); #1;
    check("clr_beat_count2", wr_count, 0);
    rd_addr = 5'd0; #1; check("clr_beat_not_stored", rd_data, 32'h0);

    // Fill all 21 entries with in_valid held high
    k = 0; cycles = 0;
    in_valid = 1'b1; in_product = 16'h1000; in_flags = 6'b000001;
    while (!full && cycles < 100) begin
      if (in_ready) k++;
      @(posedge clk); #1;
      cycles++;
      in_product = 16'h1000 + 16'(k);
    end
    check("fill_cycles", cycles, 42);
    check("fill_accepts", k, 21);
    check("fill_count", wr_count, 21);
    check("fill_full", full, 1);
    check("fill_no_overflow_yet", overflow, 0);
    in_product = 16'hDEAD;
    repeat (3) @(posedge clk);
    #1;
    check("overflow_set", overflow, 1);
    check("full_ready_low", in_ready, 0);
    check("full_count_held", wr_count, 21);
    rd_addr = 5'd20; #1; check("entry20_unchanged", rd_data, fill_word(20));
    rd_addr = 5'd0;  #1; check("entry0_fill", rd_data, fill_word(0));
    rd_addr = 5'd10; #1; check("entry10_fill", rd_data, fill_word(10));
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("overflow_sticky", overflow, 1);
    do_clear();
    check("clear_drops_overflow", overflow, 0);
    check("clear_drops_full", full, 0);

    // Async reset between edges with a write pending
    write_item(tbl[0].p, tbl[0].f, exp_word(0), 5'd0);
    in_valid = 1'b1; in_product = tbl[1].p; in_flags = tbl[1].f;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_ready", in_ready, 1);
    check("arst_count", wr_count, 0);
    rd_addr = 5'd0; #1; check("arst_read0", rd_data, 32'h0);
    rd_addr = 5'd1; #1; check("arst_read1", rd_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("arst_pending_lost", rd_data, 32'h0);
    check("arst_count_after", wr_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
